wb_queue: RTL and testbench

- Write-back queue sitting directly upstream of the 10-bit register file.
- Buffers results from the execute stage and drains one result per cycle into the register file.
- Drives each register's `chosen` (one-hot), the shared `w_en` and the shared `w_data`.
- Provides read-after-write forwarding for pending results, plus a sticky overflow error.

---
 rtl/wb_queue.sv | 96 +++++++++
 tb/tb_wb_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue between execute and the register file: FIFO of {addr, data} results,
// drains one entry per cycle, forwards pending results and flags overflow.
module wb_queue #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  input  logic                   wb_stall,
  output logic [(2**ADDR_W)-1:0] chosen,
  output logic                   w_en,
  output logic [DATA_W-1:0]      w_data,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   err
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wp_q, rp_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_q;

  logic              push;
  logic [PTR_W-1:0]  idx;

  assign w_en     = (count_q != '0) && !wb_stall;
  // A full queue still accepts when the head leaves this same cycle.
  assign in_ready = (count_q < CNT_W'(DEPTH)) || w_en;
  assign push     = in_valid && in_ready;
  assign err      = err_q;

  always_comb begin
    chosen = '0;
    w_data = '0;
    if (w_en) begin
      chosen = NREG'(1) << addr_q[rp_q];
      w_data = data_q[rp_q];
    end
  end

  // Scan oldest to youngest so the youngest matching entry overrides older ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[idx] == rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wp_q] <= in_addr;
        data_q[wp_q] <= in_data;
        wp_q         <= wp_q + 1'b1;
      end
      if (w_en) begin
        rp_q <= rp_q + 1'b1;
      end
      if (push && !w_en) begin
        count_q <= count_q + 1'b1;
      end else if (!push && w_en) begin
        count_q <= count_q - 1'b1;
      end
      if (in_valid && !in_ready) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: drain timing, stall fill, overflow, push-through,
// forwarding and mid-operation reset, all against hand-computed values.
module tb_wb_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_addr;
  logic [9:0] in_data;
  logic       in_ready;
  logic       wb_stall;
  logic [3:0] chosen;
  logic       w_en;
  logic [9:0] w_data;
  logic [1:0] rd_addr;
  logic       fwd_hit;
  logic [9:0] fwd_data;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_addr [4];
  logic [9:0] exp_data [4];

  always #5 clk = ~clk;

  wb_queue #(
    .DATA_W(10),
    .ADDR_W(2),
    .DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_addr (in_addr),
    .in_data (in_data),
    .in_ready(in_ready),
    .wb_stall(wb_stall),
    .chosen  (chosen),
    .w_en    (w_en),
    .w_data  (w_data),
    .rd_addr (rd_addr),
    .fwd_hit (fwd_hit),
    .fwd_data(fwd_data),
    .err     (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow another 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] a, input logic [9:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; wb_stall = 1'b0; rd_addr = '0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_w_en", w_en, 0);
    check("rst_chosen", chosen, 4'b0000);
    check("rst_w_data", w_data, 0);
    check("rst_err", err, 0);
    check("rst_fwd_hit", fwd_hit, 0);

    // Single write: visible the cycle after the push edge, gone the cycle after that
    push(2'd2, 10'h155);
    #1;
    check("single_w_en", w_en, 1);
    check("single_chosen", chosen, 4'b0100);
    check("single_w_data", w_data, 10'h155);
    tick();
    #1;
    check("single_w_en_after", w_en, 0);
    check("single_chosen_after", chosen, 4'b0000);

    // Fill under stall, overflow, then ordered drain
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(2'(i), 10'(i + 1));
    #1;
    check("fill_in_ready", in_ready, 0);
    check("fill_w_en_stalled", w_en, 0);
    check("fill_err_clear", err, 0);
    rd_addr = 2'd2;
    #1;
    check("fill_fwd_hit", fwd_hit, 1);
    check("fill_fwd_data", fwd_data, 10'h003);
    push(2'd0, 10'h3AA);
    #1;
    check("ovf_err", err, 1);
    wb_stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_w_en", i), w_en, 1);
      check($sformatf("drain%0d_chosen", i), chosen, 32'(4'b0001 << i));
      check($sformatf("drain%0d_w_data", i), w_data, 32'(i + 1));
      tick();
    end
    #1;
    check("drain_done_w_en", w_en, 0);
    check("drain_err_sticky", err, 1);

    // Push-through when full: clear err first
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_err", err, 0);
    wb_stall = 1'b1;
    push(2'd3, 10'h010);
    push(2'd2, 10'h020);
    push(2'd0, 10'h030);
    push(2'd3, 10'h040);
    rd_addr = 2'd3;
    #1;
    check("full_in_ready", in_ready, 0);
    check("fwd_youngest_hit", fwd_hit, 1);
    check("fwd_youngest_data", fwd_data, 10'h040);
    wb_stall = 1'b0;
    in_valid = 1'b1; in_addr = 2'd1; in_data = 10'h3FF;
    #1;
    check("pt_in_ready", in_ready, 1);
    check("pt_head_chosen", chosen, 4'b1000);
    check("pt_head_data", w_data, 10'h010);
    tick();
    in_valid = 1'b0;
    #1;
    check("pt_err", err, 0);
    exp_addr[0] = 2'd2; exp_data[0] = 10'h020;
    exp_addr[1] = 2'd0; exp_data[1] = 10'h030;
    exp_addr[2] = 2'd3; exp_data[2] = 10'h040;
    exp_addr[3] = 2'd1; exp_data[3] = 10'h3FF;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pt_drain%0d_w_en", i), w_en, 1);
      check($sformatf("pt_drain%0d_chosen", i), chosen, 32'(4'b0001 << exp_addr[i]));
      check($sformatf("pt_drain%0d_w_data", i), w_data, 32'(exp_data[i]));
      tick();
    end
    #1;
    check("pt_empty_w_en", w_en, 0);

    // Forwarding: an entry being pushed is not yet visible; youngest of two wins
    wb_stall = 1'b1;
    rd_addr  = 2'd1;
    in_valid = 1'b1; in_addr = 2'd1; in_data = 10'h011;
    #1;
    check("fwd_push_not_seen", fwd_hit, 0);
    tick();
    push(2'd1, 10'h022);
    #1;
    check("fwd_hit", fwd_hit, 1);
    check("fwd_data", fwd_data, 10'h022);
    rd_addr = 2'd0;
    #1;
    check("fwd_miss", fwd_hit, 0);
    check("fwd_miss_data", fwd_data, 0);
    rd_addr  = 2'd1;
    wb_stall = 1'b0;
    #1;
    check("fwd_popping_still_hit", fwd_hit, 1);
    check("fwd_popping_data", fwd_data, 10'h022);
    tick(); tick();
    #1;
    check("fwd_after_drain_hit", fwd_hit, 0);
    check("fwd_after_drain_data", fwd_data, 0);

    // Reset mid-operation discards pending entries
    wb_stall = 1'b1;
    push(2'd0, 10'h101);
    push(2'd1, 10'h102);
    push(2'd2, 10'h103);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb_stall = 1'b0;
    #1;
    check("midrst_w_en", w_en, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_fwd_hit", fwd_hit, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("midrst_quiet%0d", i), chosen, 4'b0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
